// File: rtl/sc_pkg.sv
// Shared definitions for the SC polar decoder processing-element array:
// operation codes and the symmetric LLR saturation bound.
package sc_pkg;

  typedef enum logic [1:0] {
    OP_F    = 2'b00,
    OP_G    = 2'b01,
    OP_PASS = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  // Largest representable LLR magnitude, 2^(w-1)-1
  function automatic int unsigned llr_max(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_pe_lane.sv
// One lane of the PE array: stage-1 logic (saturating abs, signs, wide sum)
// and stage-2 logic (op select and clamp); the registers live in the top.
module sc_pe_lane import sc_pkg::*; #(
  parameter int LLR_W = 19
) (
  input  logic [LLR_W-1:0] a_i,
  input  logic [LLR_W-1:0] b_i,
  input  logic             u_i,
  output logic [LLR_W-2:0] abs_a_o,
  output logic [LLR_W-2:0] abs_b_o,
  output logic [3:0]       flags_o,
  output logic [LLR_W:0]   sum_o,
  input  op_e              op_i,
  input  logic [LLR_W-2:0] s1_abs_a_i,
  input  logic [LLR_W-2:0] s1_abs_b_i,
  input  logic [3:0]       s1_flags_i,
  input  logic [LLR_W:0]   s1_sum_i,
  output logic [LLR_W-1:0] res_o,
  output logic             sat_o
);
  localparam logic [LLR_W-1:0]        ONE   = {{(LLR_W-1){1'b0}}, 1'b1};
  localparam logic [LLR_W-1:0]        MAX_V = LLR_W'(llr_max(LLR_W));
  localparam logic signed [LLR_W:0]   MAX_X = (LLR_W+1)'(llr_max(LLR_W));
  localparam logic signed [LLR_W:0]   MIN_X = -MAX_X;

  // MSB of the result flags that the most-negative input had to be saturated
  function automatic logic [LLR_W-1:0] sat_abs(input logic [LLR_W-1:0] x);
    logic [LLR_W-1:0] m;
    m = x[LLR_W-1] ? (~x + ONE) : x;
    return m[LLR_W-1] ? {1'b1, MAX_V[LLR_W-2:0]} : m;
  endfunction

  logic [LLR_W-1:0] abs_a_s, abs_b_s;
  logic [LLR_W-2:0] mag_s;
  logic             f_neg_s;

  // Stage 1: magnitudes, signs, abs-saturation flags and the g sum/difference
  always_comb begin
    abs_a_s = sat_abs(a_i);
    abs_b_s = sat_abs(b_i);
    abs_a_o = abs_a_s[LLR_W-2:0];
    abs_b_o = abs_b_s[LLR_W-2:0];
    flags_o = {a_i[LLR_W-1], b_i[LLR_W-1], abs_a_s[LLR_W-1], abs_b_s[LLR_W-1]};
    sum_o   = u_i ? ({b_i[LLR_W-1], b_i} - {a_i[LLR_W-1], a_i})
                  : ({b_i[LLR_W-1], b_i} + {a_i[LLR_W-1], a_i});
  end

  // Stage 2: select the op result and clamp it into [-MAX, +MAX]
  always_comb begin
    mag_s   = (s1_abs_a_i < s1_abs_b_i) ? s1_abs_a_i : s1_abs_b_i;
    f_neg_s = (s1_flags_i[3] ^ s1_flags_i[2]) && (mag_s != '0);
    res_o   = '0;
    sat_o   = 1'b0;
    case (op_i)
      OP_F: begin
        res_o = f_neg_s ? (~{1'b0, mag_s} + ONE) : {1'b0, mag_s};
        sat_o = s1_flags_i[1] | s1_flags_i[0];
      end
      OP_G: begin
        if ($signed(s1_sum_i) > MAX_X) begin
          res_o = MAX_V;
          sat_o = 1'b1;
        end else if ($signed(s1_sum_i) < MIN_X) begin
          res_o = ~MAX_V + ONE;
          sat_o = 1'b1;
        end else begin
          res_o = s1_sum_i[LLR_W-1:0];
          sat_o = 1'b0;
        end
      end
      OP_PASS: begin
        res_o = s1_flags_i[3] ? (~{1'b0, s1_abs_a_i} + ONE) : {1'b0, s1_abs_a_i};
        sat_o = s1_flags_i[1];
      end
      default: begin
        res_o = '0;
        sat_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sc_pe_array.sv
// LANES-wide two-stage PE array with valid/ready flow control on both sides;
// per-lane arithmetic is in sc_pe_lane, this module owns the pipeline registers.
module sc_pe_array import sc_pkg::*; #(
  parameter int LANES = 8,
  parameter int LLR_W = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*LLR_W-1:0] in_llr_a,
  input  logic [LANES*LLR_W-1:0] in_llr_b,
  input  logic [LANES-1:0]       in_u,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LLR_W-1:0] out_llr,
  output logic [LANES-1:0]       out_hd,
  output logic                   out_sat
);
  logic                        s1_adv_s, s2_adv_s, s1_load_s, s2_load_s;
  logic                        s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  op_e                         s1_op_q, s1_op_d;
  logic [LANES-1:0][LLR_W-2:0] abs_a_s, abs_b_s;
  logic [LANES-1:0][LLR_W-2:0] s1_abs_a_q, s1_abs_a_d, s1_abs_b_q, s1_abs_b_d;
  logic [LANES-1:0][3:0]       flags_s, s1_flags_q, s1_flags_d;
  logic [LANES-1:0][LLR_W:0]   sum_s, s1_sum_q, s1_sum_d;
  logic [LANES-1:0][LLR_W-1:0] res_s;
  logic [LANES-1:0]            res_sat_s;
  logic [LANES*LLR_W-1:0]      out_llr_q, out_llr_d;
  logic [LANES-1:0]            out_hd_q, out_hd_d;
  logic                        out_sat_q, out_sat_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sc_pe_lane #(.LLR_W(LLR_W)) u_lane (
      .a_i        (in_llr_a[i*LLR_W +: LLR_W]),
      .b_i        (in_llr_b[i*LLR_W +: LLR_W]),
      .u_i        (in_u[i]),
      .abs_a_o    (abs_a_s[i]),
      .abs_b_o    (abs_b_s[i]),
      .flags_o    (flags_s[i]),
      .sum_o      (sum_s[i]),
      .op_i       (s1_op_q),
      .s1_abs_a_i (s1_abs_a_q[i]),
      .s1_abs_b_i (s1_abs_b_q[i]),
      .s1_flags_i (s1_flags_q[i]),
      .s1_sum_i   (s1_sum_q[i]),
      .res_o      (res_s[i]),
      .sat_o      (res_sat_s[i])
    );
  end

  // Stall control and next-state for both pipeline stages
  always_comb begin
    s2_adv_s     = !out_valid_q || out_ready;
    s1_adv_s     = !s1_valid_q || s2_adv_s;
    s1_load_s    = s1_adv_s && in_valid;
    s2_load_s    = s2_adv_s && s1_valid_q;
    s1_valid_d   = s1_adv_s ? in_valid : s1_valid_q;
    s1_op_d      = s1_load_s ? op_e'(in_op) : s1_op_q;
    s1_abs_a_d   = s1_load_s ? abs_a_s : s1_abs_a_q;
    s1_abs_b_d   = s1_load_s ? abs_b_s : s1_abs_b_q;
    s1_flags_d   = s1_load_s ? flags_s : s1_flags_q;
    s1_sum_d     = s1_load_s ? sum_s : s1_sum_q;
    out_valid_d  = s2_adv_s ? s1_valid_q : out_valid_q;
    out_llr_d    = s2_load_s ? res_s : out_llr_q;
    out_sat_d    = s2_load_s ? (|res_sat_s) : out_sat_q;
    out_hd_d     = out_hd_q;
    for (int i = 0; i < LANES; i++) begin
      out_hd_d[i] = s2_load_s ? res_s[i][LLR_W-1] : out_hd_q[i];
    end
  end

  // Pipeline registers; reset discards every in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_F;
      s1_abs_a_q  <= '0;
      s1_abs_b_q  <= '0;
      s1_flags_q  <= '0;
      s1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      out_llr_q   <= '0;
      out_hd_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_abs_a_q  <= s1_abs_a_d;
      s1_abs_b_q  <= s1_abs_b_d;
      s1_flags_q  <= s1_flags_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      out_llr_q   <= out_llr_d;
      out_hd_q    <= out_hd_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = out_valid_q;
  assign out_llr   = out_llr_q;
  assign out_hd    = out_hd_q;
  assign out_sat   = out_sat_q;

endmodule
